// File: rtl/cnn_frame_driver_if.sv
// rtl/cnn_frame_driver_if.sv - frame stream and simpleCNN handshake bundle
// Purpose: groups the byte stream (s_data/s_valid/s_ready) and the simpleCNN
//   side (imgin/start/done/out) of cnn_frame_driver into one port.
// Ports (signals):
//   s_data  WORD_W    frame stream byte
//   s_valid 1         s_data valid
//   s_ready 1         driver accepts s_data
//   imgin   IMG_BITS  packed image to simpleCNN
//   start   1         one-cycle start pulse
//   done    1         simpleCNN result ready
//   out     4         simpleCNN class, valid while done=1
// Modports: master = driver view, slave = source/classifier view.
interface cnn_frame_driver_if #(
  parameter int IMG_BITS = 200,
  parameter int WORD_W   = 8
);
  logic [WORD_W-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;
  logic [IMG_BITS-1:0] imgin;
  logic                start;
  logic                done;
  logic [3:0]          out;

  modport master (
    input  s_data, s_valid, done, out,
    output s_ready, imgin, start
  );

  modport slave (
    output s_data, s_valid, done, out,
    input  s_ready, imgin, start
  );
endinterface

// File: rtl/cnn_frame_driver.sv
// rtl/cnn_frame_driver.sv - host-side frame packer and result scorer for simpleCNN
// Purpose: packs NBYTES stream bytes plus one label byte into imgin, pulses
//   start, waits for done (or times out), scores the class against the label
//   and keeps saturating accuracy counters.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   en_i           run enable, sampled only in IDLE
//   bus            cnn_frame_driver_if.master (stream + simpleCNN handshake)
//   res_valid_o    one-cycle pulse, res_* valid
//   res_class_o    captured class (4'hF on timeout)
//   res_hit_o      res_class_o == label
//   num_img_o      frames completed
//   num_hit_o      frames scored as hits
//   timeout_err_o  sticky: a frame timed out
module cnn_frame_driver #(
  parameter int IMG_BITS = 200,
  parameter int WORD_W   = 8,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  cnn_frame_driver_if.master  bus,
  output logic                res_valid_o,
  output logic [3:0]          res_class_o,
  output logic                res_hit_o,
  output logic [CNT_W-1:0]    num_img_o,
  output logic [CNT_W-1:0]    num_hit_o,
  output logic                timeout_err_o
);

  localparam int NBYTES = IMG_BITS / WORD_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [TW-1:0]    LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LABEL, S_FIRE, S_WAIT, S_RESULT
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IMG_BITS-1:0] imgin_q;
  logic [3:0]          label_q;
  logic [TW-1:0]       wait_cnt_q;
  logic [3:0]          class_q;
  logic                hit_q;
  logic [CNT_W-1:0]    num_img_q, num_hit_q;
  logic                timeout_q;

  logic       s_ready, start, res_valid, xfer;
  logic       finish;      // last WAIT cycle: done seen or timeout expired
  logic [3:0] new_class;
  logic       new_hit;

  assign xfer = bus.s_valid & s_ready;

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    finish    = 1'b0;
    new_class = 4'hF;
    new_hit   = 1'b0;
    case (state_q)
      S_IDLE:   if (en_i) state_d = S_LOAD;
      S_LOAD: begin
        s_ready = 1'b1;
        if (xfer && idx_q == LAST_IDX) state_d = S_LABEL;
      end
      S_LABEL: begin
        s_ready = 1'b1;
        if (xfer) state_d = S_FIRE;
      end
      S_FIRE: begin
        start   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done wins over an expiring timer in the same cycle
        if (bus.done) begin
          finish    = 1'b1;
          new_class = bus.out;
          new_hit   = (bus.out == label_q);
        end else if (wait_cnt_q == LAST_WAIT) begin
          finish = 1'b1;
        end
        if (finish) state_d = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      imgin_q    <= '0;
      label_q    <= '0;
      wait_cnt_q <= '0;
      class_q    <= '0;
      hit_q      <= 1'b0;
      num_img_q  <= '0;
      num_hit_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_LOAD && xfer) begin
        imgin_q[WORD_W*int'(idx_q) +: WORD_W] <= bus.s_data;
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      if (state_q == S_LABEL && xfer) label_q <= bus.s_data[3:0];
      if (state_q == S_FIRE) wait_cnt_q <= '0;
      if (state_q == S_WAIT && !finish) wait_cnt_q <= wait_cnt_q + TW'(1);
      // results and counters are updated on entry to RESULT so they are
      // already valid while res_valid_o is high
      if (finish) begin
        class_q <= new_class;
        hit_q   <= new_hit;
        if (num_img_q != '1) num_img_q <= num_img_q + CNT_W'(1);
        if (new_hit && num_hit_q != '1) num_hit_q <= num_hit_q + CNT_W'(1);
        if (!bus.done) timeout_q <= 1'b1;
      end
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.start      = start;
  assign bus.imgin      = imgin_q;
  assign res_valid_o    = res_valid;
  assign res_class_o    = class_q;
  assign res_hit_o      = hit_q;
  assign num_img_o      = num_img_q;
  assign num_hit_o      = num_hit_q;
  assign timeout_err_o  = timeout_q;

endmodule

// File: tb/tb_cnn_frame_driver.sv
// tb/tb_cnn_frame_driver.sv - self-checking bench for cnn_frame_driver
module tb_cnn_frame_driver;
  localparam int IMG_BITS = 200;
  localparam int WORD_W   = 8;
  localparam int NBYTES   = IMG_BITS / WORD_W;
  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic             res_valid, res_hit, timeout_err;
  logic [3:0]       res_class;
  logic [CNT_W-1:0] num_img, num_hit;

  cnn_frame_driver_if #(.IMG_BITS(IMG_BITS), .WORD_W(WORD_W)) bus ();

  cnn_frame_driver #(
    .IMG_BITS(IMG_BITS), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .bus(bus),
    .res_valid_o(res_valid), .res_class_o(res_class), .res_hit_o(res_hit),
    .num_img_o(num_img), .num_hit_o(num_hit), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cls;
    logic       hit;
    int         img;
    int         hitn;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_img = 0;
  int exp_hit = 0;
  logic exp_to = 1'b0;
  logic [7:0] frame_bytes [NBYTES];
  bit phase = 1'b1;

  task automatic chk(input string tag, input logic [IMG_BITS-1:0] obs, input logic [IMG_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  task automatic fill_bytes(input logic [7:0] base);
    for (int k = 0; k < NBYTES; k++) frame_bytes[k] = base + 8'(k);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit toggle);
    bit   acc = 1'b0;
    int   guard = 0;
    logic rdy;
    while (!acc && guard < 50) begin
      @(negedge clk);
      guard++;
      bus.s_data  = v;
      bus.s_valid = toggle ? phase : 1'b1;
      if (toggle) phase = !phase;
      rdy = bus.s_ready;
      @(posedge clk);
      if (bus.s_valid && rdy) acc = 1'b1;
    end
    if (!acc) chk("byte_accept", '0, 1);
  endtask

  task automatic run_frame(input logic [3:0] label, input bit toggle, input bit give_done,
                           input logic [3:0] resp, input bit fire_glitch);
    exp_t e;
    logic [IMG_BITS-1:0] exp_imgin;
    int  n;
    bit  got;
    int  lat;
    e.cls  = give_done ? resp : 4'hF;
    e.hit  = give_done && (resp == label);
    exp_img = sat_inc(exp_img);
    if (e.hit) exp_hit = sat_inc(exp_hit);
    if (!give_done) exp_to = 1'b1;
    e.img  = exp_img;
    e.hitn = exp_hit;
    e.to   = exp_to;
    sb.push_back(e);
    exp_imgin = '0;
    for (int k = 0; k < NBYTES; k++) exp_imgin[8*k +: 8] = frame_bytes[k];

    for (int k = 0; k < NBYTES; k++) send_byte(frame_bytes[k], toggle);
    send_byte({4'hA, label}, toggle);

    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("start_after_label", bus.start, 1);
    chk("s_ready_in_fire", bus.s_ready, 0);
    chk("imgin_packed", bus.imgin, exp_imgin);
    chk("imgin_byte0", bus.imgin[7:0], frame_bytes[0]);
    chk("imgin_top", bus.imgin[IMG_BITS-1 -: 8], frame_bytes[NBYTES-1]);
    if (fire_glitch) begin
      bus.done = 1'b1;
      bus.out  = 4'h9;
    end

    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      bus.done = 1'b0;
      if (n == 1) chk("start_one_pulse", bus.start, 0);
      if (res_valid) got = 1'b1;
      else if (give_done && n == 4) begin
        bus.done = 1'b1;
        bus.out  = resp;
      end
    end
    lat = give_done ? 5 : TIMEOUT + 1;
    chk("result_latency", n, lat);
    e = sb.pop_front();
    if (got) begin
      chk("res_class", res_class, e.cls);
      chk("res_hit", res_hit, e.hit);
      chk("imgin_stable", bus.imgin, exp_imgin);
      @(negedge clk);
      chk("res_valid_one_cycle", res_valid, 0);
      chk("num_img", num_img, e.img);
      chk("num_hit", num_hit, e.hitn);
      chk("timeout_err", timeout_err, e.to);
      chk("res_class_hold", res_class, e.cls);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.done    = 1'b0;
    bus.out     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_imgin", bus.imgin, 0);
    chk("rst_num_img", num_img, 0);
    chk("rst_num_hit", num_hit, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_res_class", res_class, 0);

    en = 1'b1;
    // T1: hit
    fill_bytes(8'h01);
    run_frame(4'h3, 1'b0, 1'b1, 4'h3, 1'b0);
    // T2: miss, plus a done pulse during FIRE that must be ignored
    run_frame(4'h3, 1'b0, 1'b1, 4'h7, 1'b1);
    // T3: S_VALID toggling
    run_frame(4'h3, 1'b1, 1'b1, 4'h3, 1'b0);
    // T4: timeout with saturated image counter
    fill_bytes(8'h40);
    run_frame(4'h2, 1'b0, 1'b0, 4'h2, 1'b0);
    @(negedge clk);
    chk("timeout_sticky", timeout_err, 1);

    // T5: reset after 10 bytes
    for (int k = 0; k < 10; k++) send_byte(8'h77, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_imgin", bus.imgin, 0);
    chk("midrst_num_img", num_img, 0);
    chk("midrst_num_hit", num_hit, 0);
    chk("midrst_timeout_err", timeout_err, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_hit", res_hit, 0);
    exp_img = 0;
    exp_hit = 0;
    exp_to  = 1'b0;

    // T5 continued + T6: five hit frames, counters saturate at 3
    fill_bytes(8'hA0);
    for (int f = 0; f < 5; f++) run_frame(4'h5, 1'b0, 1'b1, 4'h5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
